rx_handshake_arb: RTL
=====================

// Module: rx_handshake_arb
// PURPOSE
//  Multi-channel successor to the single-channel RX handshake. Terminates the valid/ready
//  (ready-drop acknowledge) handshake on NUM_CH RX units and captures each word. Round-robin
//  arbiter admits one word per cycle into a FIFO_DEPTH-deep buffer. Drains the buffer to
//  the router core as one-cycle rx_has_data pulses, tagged with the source channel.
// PARAMETERS
//  NUM_CH      4  number of RX channels (>=2); CH_W = $clog2(NUM_CH) is a localparam
//  DATA_W      8  width of one RX data word
//  FIFO_DEPTH  4  buffer entries (power of 2, >=2); CNT_W = $clog2(FIFO_DEPTH)+1
// PORTS
//  clk            in   1               system clock, all logic on posedge
//  rst            in   1               synchronous, active-high reset
//  RX_Data_Valid  in   NUM_CH          per-channel valid from RX units
//  RX_Data        in   NUM_CH*DATA_W   per-channel data; channel i at [i*DATA_W +: DATA_W]
//  RX_Data_Ready  out  NUM_CH          per-channel ready; a 1->0 fall while valid=1 = acknowledge
//  rc_ready       in   1               router core can accept a word this cycle
//  rx_has_data    out  1               one-cycle pulse: rx_data/rx_ch valid
//  rx_data        out  DATA_W          delivered word (held until next pulse)
//  rx_ch          out  CH_W            source channel of rx_data
//  fifo_count     out  CNT_W           current buffer occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (sampled rst=1): all channels -> RST; FIFO emptied; RR pointer = 0;
//   RX_Data_Ready = 0; rx_has_data = 0; rx_data = 0; rx_ch = 0; fifo_count = 0.
//   Reset mid-transfer abandons in-flight and buffered words; nothing is delivered for them.
//  Per-channel FSM (registered state; outputs decoded from state only):
//   RST      ready=0; -> WAIT when valid=0, else stay (wait for stale valid to clear)
//   WAIT     ready=1; -> XFER when valid=1 AND channel granted this cycle, else stay
//   XFER     ready=0; -> WAIT when valid=0, else stay
//  Request: req[i] = (state_i==WAIT) & RX_Data_Valid[i]. Grant is combinational.
//   Grant is issued only if fifo_count < FIFO_DEPTH; there is no grant when full.
//   Ready stays high for waiting channels while full; senders hold valid/data stable.
//  Arbiter: round robin; search starts at RR pointer p, ascending mod NUM_CH; first req wins.
//   After a grant to channel g, p <= (g+1) mod NUM_CH. p is unchanged with no grant.
//  Capture: on the grant edge, {g, RX_Data[g]} is written to FIFO tail, channel g -> XFER.
//   Ready for g falls the cycle after the grant.
//  Drain: pop = (fifo_count!=0) & rc_ready. On the pop edge, the registered outputs load
//   rx_has_data<=1, rx_data/rx_ch<=head. Otherwise rx_has_data<=0 and rx_data/rx_ch hold.
//   Back-to-back pulses occur when rc_ready stays high and the FIFO is non-empty.
//  Latency: grant in cycle n -> fifo_count incremented in n+1 -> rx_has_data=1 in n+2
//   (requires rc_ready=1 in n+1).
//  Simultaneous push+pop: allowed at any occupancy 1..FIFO_DEPTH-1; count unchanged.
//   When full, push is blocked even if a pop occurs the same cycle.
//  Pointers: wrap modulo FIFO_DEPTH. Order is strict FIFO across all channels.
//  rc_ready falling mid-stream stops pops the next edge; no word is lost or duplicated.
// TESTING
//  1 Reset with ch0 valid=1 held -> ready0 stays 0. Drop valid0, then raise it with data
//    0xA5 -> ready0 goes 1, then 0. rx_has_data pulses once with rx_data=0xA5, rx_ch=0.
//  2 All 4 channels valid in the same cycle (data 0x10..0x13), rc_ready=1, p=0 -> pulses in
//    order ch0, ch1, ch2, ch3 on consecutive cycles; p returns to 0.
//  3 rc_ready=0, ch1 streams 6 words (FIFO_DEPTH=4) -> fifo_count stops at 4 and ready1
//    stays 1 with no acknowledge. Set rc_ready=1 -> all 6 delivered in order, none dropped.
//  4 FIFO holds 2 words; push and pop in the same cycle -> fifo_count stays 2, order kept.
//  5 Assert rst while 3 words buffered and ch2 in XFER -> next cycle: fifo_count=0,
//    rx_has_data=0, all ready=0. No stale word is delivered after reset.
//  6 ch3 continuously requesting, ch0 requesting -> grants alternate 3, 0, 3, 0;
//    no channel is starved.

Source files
------------

// File: rtl/rx_handshake_arb.sv
// rx_handshake_arb_fifo: small synchronous FIFO that buffers {channel, word} entries.
// Latency: a push is visible at head_dat and in count on the next cycle.
// Backpressure: a push is ignored while full, even if a pop happens in the same cycle.
// Ports: clk/rst (sync, active high), push/push_dat (write tail), pop (advance head),
//        head_dat (oldest entry, valid when count != 0), count (occupancy 0..DEPTH).
module rx_handshake_arb_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The push test looks only at the current count, so a full FIFO refuses a push
    // even when a pop frees a slot on the same edge.
    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// rx_handshake_arb: terminates NUM_CH RX valid/ready handshakes, round-robin admits one word per cycle into a FIFO, drains as tagged pulses.
// Latency: grant in cycle n -> fifo_count up in n+1 -> rx_has_data pulse in n+2 (rc_ready high in n+1).
// Backpressure: no grant while the FIFO is full (waiting channels keep ready high); no pop while rc_ready is low.
// Ports: clk/rst (sync, active high); RX_Data_Valid/RX_Data in, RX_Data_Ready out (1->0 fall = ack);
//        rc_ready in; rx_has_data/rx_data/rx_ch out (registered); fifo_count out (occupancy).
module rx_handshake_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              RX_Data_Valid,
    input  logic [NUM_CH*DATA_W-1:0]       RX_Data,
    output logic [NUM_CH-1:0]              RX_Data_Ready,
    input  logic                           rc_ready,
    output logic                           rx_has_data,
    output logic [DATA_W-1:0]              rx_data,
    output logic [$clog2(NUM_CH)-1:0]      rx_ch,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CH_W + 1;
    localparam int ENT_W = CH_W + DATA_W;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } ch_state_t;

    ch_state_t         st_q [NUM_CH];
    ch_state_t         st_d [NUM_CH];
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   rr_ptr;
    logic [SUM_W-1:0]  sum;
    logic [CH_W-1:0]   idx;
    logic              fifo_full;
    logic              pop;
    logic [DATA_W-1:0] cap_dat;
    logic [ENT_W-1:0]  push_dat;
    logic [ENT_W-1:0]  head_dat;

    // ------------------------------------------------------------------
    // Per-channel handshake FSMs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i] <= ST_RST;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    // Ready and request depend only on registered state (plus valid for req), kept
    // apart from the next-state logic so the grant path does not loop back on itself.
    always_comb begin
        RX_Data_Ready = '0;
        req           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (st_q[i] == ST_WAIT) begin
                RX_Data_Ready[i] = 1'b1;
                req[i]           = RX_Data_Valid[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i] = st_q[i];
            case (st_q[i])
                // A valid left high across reset belongs to an abandoned transfer;
                // wait for it to clear before offering ready.
                ST_RST: begin
                    if (!RX_Data_Valid[i]) begin
                        st_d[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (gnt[i]) begin
                        st_d[i] = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!RX_Data_Valid[i]) begin
                        st_d[i] = ST_WAIT;
                    end
                end
                default: st_d[i] = ST_RST;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: search from rr_ptr upward, wrapping at NUM_CH.
    // ------------------------------------------------------------------
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        gnt     = '0;
        sum     = '0;
        idx     = '0;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_CH; k++) begin
                // rr_ptr and k are both below NUM_CH, so one subtraction wraps it.
                sum = {1'b0, rr_ptr} + SUM_W'(k);
                if (sum >= SUM_W'(NUM_CH)) begin
                    sum = sum - SUM_W'(NUM_CH);
                end
                idx = sum[CH_W-1:0];
                if (!gnt_vld && req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = idx;
                end
            end
        end
        if (gnt_vld) begin
            gnt = NUM_CH'(1) << gnt_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture into the FIFO and drain to the router core
    // ------------------------------------------------------------------
    always_comb begin
        cap_dat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                cap_dat = RX_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign push_dat = {gnt_ch, cap_dat};
    assign pop      = (fifo_count != '0) && rc_ready;

    rx_handshake_arb_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (gnt_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // rx_data/rx_ch hold the last delivered word between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_has_data <= 1'b0;
            rx_data     <= '0;
            rx_ch       <= '0;
        end else begin
            rx_has_data <= pop;
            if (pop) begin
                rx_ch   <= head_dat[ENT_W-1:DATA_W];
                rx_data <= head_dat[DATA_W-1:0];
            end
        end
    end
endmodule
